// File: rtl/satd_accumulator.sv
// Accumulates |Hadamard coefficients| over one block of BEATS beats and presents the SATD on valid/ready.
// Optional SATD_NORM_EN: report the rounded, right-shifted (normalised) SATD instead of the raw sum.
module satd_accumulator #(
  parameter int          CW        = 12,
  parameter int          LANES     = 4,
  parameter int          BEATS     = 8,
  parameter logic [1:0]  ACC_STAGE = 2'b11,
  parameter int          SW        = 17
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [1:0]            stage,
  input  logic [2:0]            count,
  input  logic                  coef_valid,
  input  logic [LANES*CW-1:0]   coef_data,
  output logic [SW-1:0]         satd,
  output logic                  satd_valid,
  input  logic                  satd_ready,
  output logic                  busy,
  output logic                  seq_err,
  output logic                  overrun
);

  typedef enum logic [1:0] {IDLE, ACC, HOLD} state_t;

  localparam logic [2:0] LAST = 3'(BEATS - 1);

  state_t        state, state_nxt;
  logic [SW-1:0] acc, acc_nxt, satd_nxt, beat_sum;
  logic [2:0]    exp_cnt, exp_nxt;
  logic          satd_valid_nxt, seq_err_nxt, overrun_nxt;
  logic          beat, start;

  // Unsigned CW-bit magnitude: -2^(CW-1) maps exactly to 2^(CW-1).
  function automatic logic [CW-1:0] abs_u(input logic [CW-1:0] c);
    return c[CW-1] ? -c : c;
  endfunction

`ifdef SATD_NORM_EN
  localparam int         NSH = ((BEATS * LANES) / 16 > 1) ? 2 : 1;
  localparam logic [SW:0] RND = (SW+1)'(1) << (NSH - 1);
  function automatic logic [SW-1:0] norm(input logic [SW-1:0] raw);
    logic [SW:0] t;
    t = {1'b0, raw} + RND;
    return SW'(t >> NSH);
  endfunction
`else
  function automatic logic [SW-1:0] norm(input logic [SW-1:0] raw);
    return raw;
  endfunction
`endif

  assign beat = coef_valid && (stage == ACC_STAGE);
  assign busy = (state == ACC);

  always_comb begin
    beat_sum = '0;
    for (int i = 0; i < LANES; i++)
      beat_sum = beat_sum + SW'(abs_u(coef_data[i*CW +: CW]));
  end

  always_comb begin
    state_nxt      = state;
    acc_nxt        = acc;
    exp_nxt        = exp_cnt;
    satd_nxt       = satd;
    satd_valid_nxt = satd_valid;
    seq_err_nxt    = seq_err;
    overrun_nxt    = overrun;
    start          = 1'b0;
    case (state)
      IDLE: start = beat;
      ACC: begin
        if (beat) begin
          if (count == 3'd0) begin
            acc_nxt = beat_sum;
            exp_nxt = 3'd1;
          end else if (count == exp_cnt && exp_cnt == LAST) begin
            satd_nxt       = norm(acc + beat_sum);
            satd_valid_nxt = 1'b1;
            state_nxt      = HOLD;
          end else if (count == exp_cnt) begin
            acc_nxt = acc + beat_sum;
            exp_nxt = exp_cnt + 3'd1;
          end else begin
            seq_err_nxt = 1'b1;
            acc_nxt     = '0;
            state_nxt   = IDLE;
          end
        end
      end
      HOLD: begin
        if (!satd_ready) begin
          if (beat) overrun_nxt = 1'b1;
        end else begin
          satd_valid_nxt = 1'b0;
          state_nxt      = IDLE;
          start          = beat;
        end
      end
      default: state_nxt = IDLE;
    endcase

    // Block start: shared by IDLE and the HOLD cycle in which the result is taken.
    if (start) begin
      if (count == 3'd0) begin
        if (BEATS == 1) begin
          satd_nxt       = norm(beat_sum);
          satd_valid_nxt = 1'b1;
          state_nxt      = HOLD;
        end else begin
          acc_nxt   = beat_sum;
          exp_nxt   = 3'd1;
          state_nxt = ACC;
        end
      end else begin
        seq_err_nxt = 1'b1;
        state_nxt   = IDLE;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      acc        <= '0;
      exp_cnt    <= 3'd0;
      satd       <= '0;
      satd_valid <= 1'b0;
      seq_err    <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      state      <= state_nxt;
      acc        <= acc_nxt;
      exp_cnt    <= exp_nxt;
      satd       <= satd_nxt;
      satd_valid <= satd_valid_nxt;
      seq_err    <= seq_err_nxt;
      overrun    <= overrun_nxt;
    end
  end

endmodule

// File: tb/tb_satd_accumulator.sv
// Directed, self-checking bench for satd_accumulator (default parameters).
module tb_satd_accumulator;

  logic        clk = 1'b0;
  logic        reset;
  logic [1:0]  stage;
  logic [2:0]  count;
  logic        coef_valid;
  logic [47:0] coef_data;
  logic [16:0] satd;
  logic        satd_valid;
  logic        satd_ready;
  logic        busy;
  logic        seq_err;
  logic        overrun;

  int errors = 0;
  int checks = 0;

  satd_accumulator dut (
    .clk(clk), .reset(reset), .stage(stage), .count(count),
    .coef_valid(coef_valid), .coef_data(coef_data),
    .satd(satd), .satd_valid(satd_valid), .satd_ready(satd_ready),
    .busy(busy), .seq_err(seq_err), .overrun(overrun)
  );

  always #5 clk = ~clk;

  function automatic logic [47:0] pack4(input int a, input int b, input int c, input int d);
    logic [11:0] l0, l1, l2, l3;
    l0 = 12'(a); l1 = 12'(b); l2 = 12'(c); l3 = 12'(d);
    return {l3, l2, l1, l0};
  endfunction

  function automatic logic [16:0] expv(input int raw);
`ifdef SATD_NORM_EN
    return 17'((raw + 2) >> 2);
`else
    return 17'(raw);
`endif
  endfunction

  task automatic cycle(input logic v, input logic [1:0] st, input logic [2:0] cnt,
                       input logic [47:0] d, input logic rdy);
    coef_valid = v; stage = st; count = cnt; coef_data = d; satd_ready = rdy;
    @(posedge clk); #1;
    coef_valid = 1'b0;
  endtask

  task automatic run_block(input logic [47:0] d, input int first, input int last, input logic rdy);
    for (int k = first; k <= last; k++) cycle(1'b1, 2'b11, 3'(k), d, rdy);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    cycle(1'b0, 2'b00, 3'd0, 48'd0, 1'b0);
    reset = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    if (satd !== 17'd0) begin errors++; $display("FAIL reset_satd: got %0d want 0", satd); end
    checks++;
    if (satd_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", satd_valid); end
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
    checks++;
    if ({seq_err, overrun} !== 2'b00) begin errors++; $display("FAIL reset_flags: got %b want 00", {seq_err, overrun}); end
    checks++;
  endtask

  task automatic test_basic();
    logic [47:0] one = pack4(1, 1, 1, 1);
    run_block(one, 0, 0, 1'b1);
    if (busy !== 1'b1) begin errors++; $display("FAIL basic_busy: got %b want 1", busy); end
    checks++;
    run_block(one, 1, 3, 1'b1);
    // Foreign stage and non-valid beats must not disturb the block.
    cycle(1'b1, 2'b10, 3'd4, pack4(999, 999, 999, 999), 1'b1);
    cycle(1'b0, 2'b11, 3'd4, pack4(500, 500, 500, 500), 1'b1);
    run_block(one, 4, 6, 1'b1);
    if (satd_valid !== 1'b0) begin errors++; $display("FAIL basic_early_valid: got %b want 0", satd_valid); end
    checks++;
    run_block(one, 7, 7, 1'b1);
    if (satd_valid !== 1'b1) begin errors++; $display("FAIL basic_valid: got %b want 1", satd_valid); end
    checks++;
    if (satd !== expv(32)) begin errors++; $display("FAIL basic_satd: got %0d want %0d", satd, expv(32)); end
    checks++;
    cycle(1'b0, 2'b00, 3'd0, 48'd0, 1'b1);
    if ({satd_valid, busy} !== 2'b00) begin errors++; $display("FAIL basic_drain: got %b want 00", {satd_valid, busy}); end
    checks++;
  endtask

  task automatic test_max();
    run_block(pack4(-2048, -2048, -2048, -2048), 0, 7, 1'b1);
    if (satd !== expv(65536)) begin errors++; $display("FAIL max_satd: got %0d want %0d", satd, expv(65536)); end
    checks++;
    if ({seq_err, overrun} !== 2'b00) begin errors++; $display("FAIL max_flags: got %b want 00", {seq_err, overrun}); end
    checks++;
    cycle(1'b0, 2'b00, 3'd0, 48'd0, 1'b1);
  endtask

  task automatic test_seq_err();
    logic [47:0] two = pack4(2, -2, 2, -2);
    run_block(two, 0, 2, 1'b1);
    cycle(1'b1, 2'b11, 3'd4, two, 1'b1);
    if (seq_err !== 1'b1) begin errors++; $display("FAIL seq_err_set: got %b want 1", seq_err); end
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL seq_err_idle: busy got %b want 0", busy); end
    checks++;
    run_block(two, 0, 7, 1'b1);
    if (satd !== expv(64) || satd_valid !== 1'b1) begin
      errors++; $display("FAIL seq_err_next: got %0d/%b want %0d/1", satd, satd_valid, expv(64));
    end
    checks++;
    cycle(1'b0, 2'b00, 3'd0, 48'd0, 1'b1);
    if (seq_err !== 1'b1) begin errors++; $display("FAIL seq_err_sticky: got %b want 1", seq_err); end
    checks++;
  endtask

  task automatic test_overrun();
    do_reset();
    run_block(pack4(3, 3, -3, 3), 0, 7, 1'b0);
    for (int k = 0; k < 5; k++) begin
      cycle(k == 2, 2'b11, 3'd0, pack4(100, 100, 100, 100), 1'b0);
      if (satd_valid !== 1'b1 || satd !== expv(96)) begin
        errors++; $display("FAIL overrun_hold%0d: got %0d/%b want %0d/1", k, satd, satd_valid, expv(96));
      end
      checks++;
    end
    if (overrun !== 1'b1) begin errors++; $display("FAIL overrun_set: got %b want 1", overrun); end
    checks++;
    cycle(1'b0, 2'b00, 3'd0, 48'd0, 1'b1);
    if (satd_valid !== 1'b0) begin errors++; $display("FAIL overrun_release: got %b want 0", satd_valid); end
    checks++;
    run_block(pack4(1, 1, 1, 1), 0, 7, 1'b1);
    if (satd !== expv(32)) begin errors++; $display("FAIL overrun_next: got %0d want %0d", satd, expv(32)); end
    checks++;
    cycle(1'b0, 2'b00, 3'd0, 48'd0, 1'b1);
  endtask

  task automatic test_back_to_back();
    do_reset();
    run_block(pack4(1, -3, 5, -7), 0, 7, 1'b1);
    if (satd !== expv(128) || satd_valid !== 1'b1) begin
      errors++; $display("FAIL b2b_first: got %0d/%b want %0d/1", satd, satd_valid, expv(128));
    end
    checks++;
    run_block(pack4(-2048, 2047, 0, -1), 0, 0, 1'b1);
    if ({satd_valid, busy} !== 2'b01) begin errors++; $display("FAIL b2b_restart: got %b want 01", {satd_valid, busy}); end
    checks++;
    run_block(pack4(-2048, 2047, 0, -1), 1, 7, 1'b1);
    if (satd !== expv(32768) || satd_valid !== 1'b1) begin
      errors++; $display("FAIL b2b_second: got %0d/%b want %0d/1", satd, satd_valid, expv(32768));
    end
    checks++;
    if ({seq_err, overrun} !== 2'b00) begin errors++; $display("FAIL b2b_flags: got %b want 00", {seq_err, overrun}); end
    checks++;
    cycle(1'b0, 2'b00, 3'd0, 48'd0, 1'b1);
  endtask

  task automatic test_reset_mid();
    cycle(1'b1, 2'b11, 3'd3, pack4(1, 1, 1, 1), 1'b1);
    if (seq_err !== 1'b1) begin errors++; $display("FAIL idle_bad_count: seq_err got %b want 1", seq_err); end
    checks++;
    run_block(pack4(5, 5, 5, 5), 0, 3, 1'b1);
    do_reset();
    if ({satd_valid, busy, seq_err, overrun} !== 4'b0000 || satd !== 17'd0) begin
      errors++; $display("FAIL mid_reset: got %b satd=%0d want 0000 satd=0", {satd_valid, busy, seq_err, overrun}, satd);
    end
    checks++;
    for (int k = 0; k < 8; k++) begin
      cycle(1'b1, 2'b11, 3'(k), pack4(1, -1, 1, -1), 1'b1);
      cycle(1'b1, 2'(k % 3), 3'd0, pack4(77, 77, 77, 77), 1'b1);
    end
    if (satd_valid !== 1'b0) begin errors++; $display("FAIL fresh_valid_drop: got %b want 0", satd_valid); end
    checks++;
    if (satd !== expv(32) || seq_err !== 1'b0) begin
      errors++; $display("FAIL fresh_sum: got %0d err=%b want %0d err=0", satd, seq_err, expv(32));
    end
    checks++;
  endtask

  initial begin
    reset = 1'b1; stage = 2'b00; count = 3'd0; coef_valid = 1'b0;
    coef_data = 48'd0; satd_ready = 1'b0;
    @(posedge clk); #1;
    test_reset();
    test_basic();
    test_max();
    test_seq_err();
    test_overrun();
    test_back_to_back();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
